// File: rtl/id_pkg.sv
// id_pkg: opcodes, execute/branch codes and the 9-bit control bundle shared by the ID stage.
package id_pkg;
  localparam logic [5:0] OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND = 6'd5,
                         OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,  OP_SLA = 6'd9,
                         OP_SLL  = 6'd10, OP_SRA  = 6'd11, OP_SRL  = 6'd12, OP_ADDI = 6'd32,
                         OP_SUBI = 6'd33, OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ = 6'd40,
                         OP_BNE  = 6'd41, OP_JMP  = 6'd42;
  typedef enum logic [3:0] {
    EXE_NOP, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_NOR, EXE_XOR, EXE_SLA, EXE_SLL, EXE_SRA, EXE_SRL
  } exe_cmd_e;
  typedef enum logic [1:0] {BR_NONE, BR_BEZ, BR_BNE, BR_JMP} br_type_e;
  typedef struct packed {
    logic     wb_en;
    logic     mem_rd;
    logic     mem_wr;
    br_type_e br_type;
    exe_cmd_e exe_cmd;
  } ctrl_t;
endpackage

// File: rtl/id_ctrl_dec.sv
// id_ctrl_dec: opcode to control bundle, immediate and two-source flags.
module id_ctrl_dec
  import id_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       is_immediate,
  output logic       is_two_source
);
  logic r_type;
  always_comb begin
    ctrl = '0;
    r_type = 1'b1;
    is_immediate = 1'b0;
    case (opcode)
      OP_ADD:  ctrl.exe_cmd = EXE_ADD;
      OP_SUB:  ctrl.exe_cmd = EXE_SUB;
      OP_AND:  ctrl.exe_cmd = EXE_AND;
      OP_OR:   ctrl.exe_cmd = EXE_OR;
      OP_NOR:  ctrl.exe_cmd = EXE_NOR;
      OP_XOR:  ctrl.exe_cmd = EXE_XOR;
      OP_SLA:  ctrl.exe_cmd = EXE_SLA;
      OP_SLL:  ctrl.exe_cmd = EXE_SLL;
      OP_SRA:  ctrl.exe_cmd = EXE_SRA;
      OP_SRL:  ctrl.exe_cmd = EXE_SRL;
      default: r_type = 1'b0;
    endcase
    ctrl.wb_en = r_type;
    is_two_source = r_type;
    case (opcode)
      OP_ADDI: begin ctrl.wb_en = 1'b1; ctrl.exe_cmd = EXE_ADD; is_immediate = 1'b1; end
      OP_SUBI: begin ctrl.wb_en = 1'b1; ctrl.exe_cmd = EXE_SUB; is_immediate = 1'b1; end
      OP_LD:   begin ctrl.wb_en = 1'b1; ctrl.mem_rd = 1'b1; ctrl.exe_cmd = EXE_ADD; is_immediate = 1'b1; end
      OP_ST:   begin ctrl.mem_wr = 1'b1; ctrl.exe_cmd = EXE_ADD; is_immediate = 1'b1; is_two_source = 1'b1; end
      OP_BEZ:  begin ctrl.br_type = BR_BEZ; is_immediate = 1'b1; end
      OP_BNE:  begin ctrl.br_type = BR_BNE; is_immediate = 1'b1; is_two_source = 1'b1; end
      OP_JMP:  begin ctrl.br_type = BR_JMP; is_immediate = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, pending-write scoreboard and ID->EX register.
// ID_WB_BYPASS_EN forwards the same-cycle write-back into reads and the scoreboard view.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_val1,
  output logic [XLEN-1:0] out_val2,
  output logic [XLEN-1:0] out_st_val,
  output logic [RW-1:0]   out_dest,
  output logic            out_wb_en,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [1:0]      out_br_type,
  output logic [3:0]      out_exe_cmd,
  output logic            hazard
);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};
  ctrl_t ctrl;
  logic is_imm, two_src, accept, xfer;
  logic [RW-1:0] src1, src2, dest;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] regs [NREG];
  logic [PEND_W-1:0] pend [NREG];
  id_ctrl_dec u_dec (
    .opcode(in_instr[31:26]),
    .ctrl(ctrl),
    .is_immediate(is_imm),
    .is_two_source(two_src)
  );
  function automatic logic [XLEN-1:0] rd_reg(input logic [RW-1:0] a);
`ifdef ID_WB_BYPASS_EN
    return (wb_en && a == wb_dest && a != '0) ? wb_val : regs[a];
`else
    return regs[a];
`endif
  endfunction
  // Outstanding writes as seen by a new reader: the counter plus a writer still parked in the
  // ID->EX register, which has not been counted yet because it has not transferred.
  function automatic logic [PEND_W:0] pend_eff(input logic [RW-1:0] a);
    logic [PEND_W:0] c;
    c = {1'b0, pend[a]} + (PEND_W+1)'(out_valid && out_wb_en && out_dest == a && a != '0);
`ifdef ID_WB_BYPASS_EN
    c = c - (PEND_W+1)'(wb_en && wb_dest == a && a != '0 && pend[a] != '0);
`endif
    return c;
  endfunction
  assign src1 = RW'(in_instr[25:21]);
  assign src2 = RW'(in_instr[20:16]);
  assign dest = is_imm ? src2 : RW'(in_instr[15:11]);
  assign imm_ext = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign hazard = in_valid && (pend_eff(src1) != '0 || (two_src && pend_eff(src2) != '0) ||
                               (ctrl.wb_en && pend_eff(dest) == PEND_MAX));
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign accept = in_valid && in_ready && !flush;
  assign xfer = out_valid && out_ready && !flush;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int r = 0; r < NREG; r++) regs[r] <= '0;
    else if (wb_en && wb_dest != '0) regs[wb_dest] <= wb_val;
  // Killed (flushed) instructions never reach the counter; decrements of zero are dropped.
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int r = 0; r < NREG; r++) pend[r] <= '0;
    else for (int r = 1; r < NREG; r++)
      pend[r] <= pend[r] + PEND_W'(xfer && out_wb_en && out_dest == RW'(r))
                         - PEND_W'(wb_en && wb_dest == RW'(r) && pend[r] != '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_val1 <= '0;
      out_val2 <= '0;
      out_st_val <= '0;
      out_dest <= '0;
      out_wb_en <= 1'b0;
      out_mem_rd <= 1'b0;
      out_mem_wr <= 1'b0;
      out_br_type <= '0;
      out_exe_cmd <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (accept) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_val1 <= rd_reg(src1);
      out_val2 <= is_imm ? imm_ext : rd_reg(src2);
      out_st_val <= rd_reg(src2);
      out_dest <= dest;
      out_wb_en <= ctrl.wb_en;
      out_mem_rd <= ctrl.mem_rd;
      out_mem_wr <= ctrl.mem_wr;
      out_br_type <= ctrl.br_type;
      out_exe_cmd <= ctrl.exe_cmd;
    end else if (xfer) out_valid <= 1'b0;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of decode, scoreboard stalls, back-pressure, flush and reset.
module tb_id_stage_pipe;
  import id_pkg::*;
  logic clk = 0, rst = 0;
  logic in_valid = 0, flush = 0, wb_en = 0, out_ready = 1;
  logic [31:0] in_pc = 0, in_instr = 0, wb_val = 0;
  logic [4:0] wb_dest = 0;
  logic in_ready, out_valid, out_wb_en, out_mem_rd, out_mem_wr, hazard;
  logic [31:0] out_pc, out_val1, out_val2, out_st_val;
  logic [4:0] out_dest;
  logic [1:0] out_br_type;
  logic [3:0] out_exe_cmd;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_val1(out_val1),
    .out_val2(out_val2), .out_st_val(out_st_val), .out_dest(out_dest), .out_wb_en(out_wb_en),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_br_type(out_br_type),
    .out_exe_cmd(out_exe_cmd), .hazard(hazard)
  );
  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] s1, s2, rd);
    return {op, s1, s2, rd, 11'd0};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] s1, s2, input logic [15:0] imm);
    return {op, s1, s2, imm};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb_pulse(input logic [4:0] d, input logic [31:0] v);
    wb_en = 1; wb_dest = d; wb_val = v;
    tick();
    wb_en = 0;
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 0;
  endtask
  task automatic test_reset();
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if ({out_pc, out_dest, out_wb_en, out_exe_cmd} !== '0) begin fails++; $display("FAIL reset_outs: got pc=%h dest=%0d wb=%b cmd=%0d want 0", out_pc, out_dest, out_wb_en, out_exe_cmd); end
    tick();
    rst = 1;
  endtask
  task automatic test_raw();
    in_valid = 1; in_instr = ii(OP_ADDI, 0, 1, 16'd5); in_pc = 32'h100;
    #1;
    tests++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL raw_first: hazard=%b ready=%b want 0/1", hazard, in_ready); end
    tick();
    tests++; if (out_valid !== 1 || out_dest !== 5'd1 || out_val2 !== 32'd5 || out_val1 !== 0 || out_wb_en !== 1 || out_exe_cmd !== 4'd1 || out_pc !== 32'h100)
      begin fails++; $display("FAIL raw_addi: v=%b dest=%0d v1=%h v2=%h wb=%b cmd=%0d pc=%h", out_valid, out_dest, out_val1, out_val2, out_wb_en, out_exe_cmd, out_pc); end
    in_instr = ri(OP_ADD, 1, 1, 2); in_pc = 32'h104;
    #1;
    tests++; if (hazard !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL raw_inflight: hazard=%b ready=%b want 1/0", hazard, in_ready); end
    tick();
    tick();
    tests++; if (hazard !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL raw_pending: hazard=%b valid=%b want 1/0", hazard, out_valid); end
    wb_en = 1; wb_dest = 1; wb_val = 5;
    #1;
`ifdef ID_WB_BYPASS_EN
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL raw_wb_cycle: hazard got %b want 0", hazard); end
`else
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL raw_wb_cycle: hazard got %b want 1", hazard); end
`endif
    tick();
    wb_en = 0;
`ifndef ID_WB_BYPASS_EN
    tests++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL raw_after_wb: hazard=%b ready=%b want 0/1", hazard, in_ready); end
    tick();
`endif
    in_valid = 0;
    tests++; if (out_valid !== 1 || out_val1 !== 32'd5 || out_val2 !== 32'd5 || out_dest !== 5'd2 || out_pc !== 32'h104)
      begin fails++; $display("FAIL raw_add: v=%b v1=%h v2=%h dest=%0d pc=%h want 1/5/5/2/104", out_valid, out_val1, out_val2, out_dest, out_pc); end
    tick();
    wb_pulse(2, 32'd10);
  endtask
  task automatic test_stall();
    out_ready = 0;
    issue(ii(OP_ADDI, 0, 4, 16'd7), 32'h200);
    in_valid = 1; in_instr = ii(OP_ADDI, 0, 5, 16'd9); in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 0 || out_valid !== 1 || out_pc !== 32'h200 || out_val2 !== 32'd7 || out_dest !== 5'd4)
        begin fails++; $display("FAIL stall_hold%0d: ready=%b v=%b pc=%h v2=%h dest=%0d", i, in_ready, out_valid, out_pc, out_val2, out_dest); end
      tick();
    end
    out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release: ready got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1 || out_pc !== 32'h204 || out_val2 !== 32'd9 || out_dest !== 5'd5)
      begin fails++; $display("FAIL stall_next: v=%b pc=%h v2=%h dest=%0d", out_valid, out_pc, out_val2, out_dest); end
    tick();
    wb_pulse(4, 32'd7);
    wb_pulse(5, 32'd9);
    in_valid = 1; in_instr = ri(OP_ADD, 4, 5, 6);
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL stall_single_xfer: hazard got %b want 0", hazard); end
    in_valid = 0;
  endtask
  task automatic test_flush();
    out_ready = 0;
    issue(ii(OP_ADDI, 0, 6, 16'd1), 32'h300);
    in_valid = 1; in_instr = ii(OP_ADDI, 0, 7, 16'd2); flush = 1; out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_kill: valid got %b want 0", out_valid); end
    in_valid = 1; in_instr = ri(OP_ADD, 6, 7, 8); in_pc = 32'h308;
    #1;
    tests++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_pend: hazard=%b ready=%b want 0/1", hazard, in_ready); end
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1 || out_dest !== 5'd8 || out_val1 !== 0 || out_exe_cmd !== 4'd1 || out_pc !== 32'h308)
      begin fails++; $display("FAIL flush_next: v=%b dest=%0d v1=%h cmd=%0d pc=%h", out_valid, out_dest, out_val1, out_exe_cmd, out_pc); end
    tick();
    wb_pulse(8, 32'd0);
  endtask
  task automatic test_pend_sat();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_instr = ii(OP_ADDI, 0, 3, 16'(i + 1));
      #1;
      tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL sat_accept%0d: hazard got %b want 0", i, hazard); end
      tick();
    end
    in_instr = ii(OP_ADDI, 0, 3, 16'd4);
    #1;
    tests++; if (hazard !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL sat_hold: hazard=%b ready=%b want 1/0", hazard, in_ready); end
    tick();
    tests++; if (hazard !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL sat_full: hazard=%b valid=%b want 1/0", hazard, out_valid); end
    wb_en = 1; wb_dest = 3; wb_val = 1;
    #1;
`ifdef ID_WB_BYPASS_EN
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL sat_wb: hazard got %b want 0", hazard); end
`else
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL sat_wb: hazard got %b want 1", hazard); end
`endif
    tick();
    wb_en = 0;
`ifndef ID_WB_BYPASS_EN
    tick();
`endif
    in_valid = 0;
    tests++; if (out_valid !== 1 || out_dest !== 5'd3 || out_val2 !== 32'd4) begin fails++; $display("FAIL sat_release: v=%b dest=%0d v2=%h", out_valid, out_dest, out_val2); end
    tick();
    wb_en = 1; wb_dest = 3; wb_val = 4;
    repeat (3) tick();
    wb_en = 0;
  endtask
  task automatic test_r0();
    wb_en = 1; wb_dest = 0; wb_val = 32'hFFFF_FFFF;
    in_valid = 1; in_instr = ri(OP_ADD, 0, 0, 9);
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL r0_hazard: got %b want 0", hazard); end
    tick();
    wb_en = 0;
    in_instr = ii(OP_ADDI, 0, 0, 16'd1);
    tests++; if (out_val1 !== 0 || out_val2 !== 0) begin fails++; $display("FAIL r0_same_cycle: v1=%h v2=%h want 0", out_val1, out_val2); end
    tick();
    in_instr = ri(OP_ADD, 0, 0, 10);
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL r0_inflight: hazard got %b want 0", hazard); end
    tick();
    in_instr = ri(OP_ADD, 0, 0, 11);
    #1;
    tests++; if (hazard !== 1'b0 || out_val1 !== 0) begin fails++; $display("FAIL r0_pend: hazard=%b v1=%h want 0/0", hazard, out_val1); end
    tick();
    in_valid = 0;
    tick();
    wb_pulse(9, 0);
    wb_pulse(10, 0);
    wb_pulse(11, 0);
  endtask
  task automatic test_decode();
    issue(ii(OP_ST, 0, 1, 16'hFFFC), 32'h400);
    tests++; if (out_mem_wr !== 1 || out_wb_en !== 0 || out_val2 !== 32'hFFFF_FFFC || out_st_val !== 32'd5 || out_exe_cmd !== 4'd1)
      begin fails++; $display("FAIL dec_st: mw=%b wb=%b v2=%h st=%h cmd=%0d", out_mem_wr, out_wb_en, out_val2, out_st_val, out_exe_cmd); end
    issue({6'd63, 5'd1, 5'd2, 5'd3, 11'h7FF}, 32'h404);
    tests++; if ({out_wb_en, out_mem_rd, out_mem_wr, out_br_type, out_exe_cmd} !== 9'd0 || out_valid !== 1)
      begin fails++; $display("FAIL dec_unknown: ctrl=%b valid=%b want 0/1", {out_wb_en, out_mem_rd, out_mem_wr, out_br_type, out_exe_cmd}, out_valid); end
    issue(ii(OP_BNE, 1, 0, 16'h0010), 32'h408);
    tests++; if (out_br_type !== 2'd2 || out_val1 !== 32'd5 || out_val2 !== 32'h10 || out_wb_en !== 0)
      begin fails++; $display("FAIL dec_bne: br=%0d v1=%h v2=%h wb=%b", out_br_type, out_val1, out_val2, out_wb_en); end
    issue(ii(OP_LD, 1, 12, 16'h0008), 32'h40C);
    tests++; if (out_mem_rd !== 1 || out_wb_en !== 1 || out_dest !== 5'd12 || out_val1 !== 32'd5 || out_val2 !== 32'd8)
      begin fails++; $display("FAIL dec_ld: mr=%b wb=%b dest=%0d v1=%h v2=%h", out_mem_rd, out_wb_en, out_dest, out_val1, out_val2); end
    tick();
    wb_pulse(12, 0);
  endtask
  task automatic test_async_reset();
    issue(ii(OP_ADDI, 0, 10, 16'd1), 32'h500);
    tick();
    out_ready = 0;
    issue(ii(OP_ADDI, 0, 13, 16'd3), 32'h504);
    #2;
    rst = 0;
    #1;
    tests++; if (out_valid !== 0 || out_dest !== 0 || out_val2 !== 0 || out_pc !== 0)
      begin fails++; $display("FAIL areset_outs: v=%b dest=%0d v2=%h pc=%h want 0", out_valid, out_dest, out_val2, out_pc); end
    tick();
    rst = 1; out_ready = 1;
    in_valid = 1; in_instr = ri(OP_ADD, 1, 10, 12); in_pc = 32'h508;
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL areset_pend: hazard got %b want 0", hazard); end
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1 || out_val1 !== 0 || out_val2 !== 0) begin fails++; $display("FAIL areset_regs: v=%b v1=%h v2=%h want 1/0/0", out_valid, out_val1, out_val2); end
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_raw();
    test_stall();
    test_flush();
    test_pend_sat();
    test_r0();
    test_decode();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
